// File: rtl/sap1_program_loader_pkg.sv
// rtl/sap1_program_loader_pkg.sv - shared widths and loader state encoding
package sap1_program_loader_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_FULL    = 2'd2,
      ST_RELEASE = 2'd3
   } loader_state_e;

endpackage

// File: rtl/sap1_program_loader_ram.sv
// rtl/sap1_program_loader_ram.sv - program RAM, one write port and one registered read port
module program_ram_16x8
   import sap1_program_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Contents survive reset; a same-address read sees the pre-write word.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)  rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sap1_program_loader.sv
// rtl/sap1_program_loader.sv - loads SAP-1 program RAM from pins via 4-phase strobe/ack
module sap1_program_loader
   import sap1_program_loader_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load_mode_i,
   input  logic              data_strobe_i,
   input  logic [DATA_W-1:0] data_in_i,
   output logic              load_ack_o,
   output logic [ADDR_W-1:0] load_addr_o,
   output logic              load_done_o,
   output logic              overflow_o,
   output logic              cpu_hold_o,
   input  logic              cpu_rd_en_i,
   input  logic [ADDR_W-1:0] cpu_rd_addr_i,
   output logic [DATA_W-1:0] cpu_rd_data_o
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   logic [SYNC_STAGES-1:0] mode_sync_q;
   logic [SYNC_STAGES-1:0] stb_sync_q;
   logic                   stb_prev_q;
   logic                   mode_s;
   logic                   stb_s;
   logic                   stb_rise;
   logic                   wr_en;

   loader_state_e     state_q;
   logic [ADDR_W-1:0] load_addr_q;
   logic              load_ack_q;
   logic              load_done_q;
   logic              overflow_q;
   logic              cpu_hold_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         mode_sync_q <= '0;
         stb_sync_q  <= '0;
         stb_prev_q  <= 1'b0;
      end else begin
         mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], load_mode_i};
         stb_sync_q  <= {stb_sync_q[SYNC_STAGES-2:0], data_strobe_i};
         stb_prev_q  <= stb_s;
      end
   end

   assign mode_s   = mode_sync_q[SYNC_STAGES-1];
   assign stb_s    = stb_sync_q[SYNC_STAGES-1];
   assign stb_rise = stb_s & ~stb_prev_q;

   // Gated by reset so a write pending in the reset cycle is dropped.
   assign wr_en = rst_n_i & (state_q == ST_LOAD) & stb_rise & ~load_ack_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         load_addr_q <= '0;
         load_ack_q  <= 1'b0;
         load_done_q <= 1'b0;
         overflow_q  <= 1'b0;
         cpu_hold_q  <= 1'b0;
      end else begin
         if (load_ack_q && !stb_s) load_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (mode_s) begin
                  state_q     <= ST_LOAD;
                  load_addr_q <= '0;
                  load_done_q <= 1'b0;
                  overflow_q  <= 1'b0;
                  cpu_hold_q  <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (wr_en) begin
                  load_ack_q  <= 1'b1;
                  load_addr_q <= load_addr_q + 1'b1;
                  if (load_addr_q == ADDR_LAST) begin
                     load_done_q <= 1'b1;
                     state_q     <= ST_FULL;
                  end
               end
               if (!mode_s) state_q <= ST_RELEASE;
            end
            ST_FULL: begin
               if (stb_rise) overflow_q <= 1'b1;
               if (!mode_s)  state_q    <= ST_RELEASE;
            end
            default: begin
               state_q    <= ST_IDLE;
               cpu_hold_q <= 1'b0;
            end
         endcase
      end
   end

   program_ram_16x8 #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .we_i    (wr_en),
      .waddr_i (load_addr_q),
      .wdata_i (data_in_i),
      .re_i    (cpu_rd_en_i),
      .raddr_i (cpu_rd_addr_i),
      .rdata_o (cpu_rd_data_o)
   );

   assign load_ack_o  = load_ack_q;
   assign load_addr_o = load_addr_q;
   assign load_done_o = load_done_q;
   assign overflow_o  = overflow_q;
   assign cpu_hold_o  = cpu_hold_q;

endmodule

// File: tb/tb_sap1_program_loader.sv
// tb/tb_sap1_program_loader.sv - directed self-checking bench for sap1_program_loader
module tb_sap1_program_loader;
   import sap1_program_loader_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_mode;
   logic       data_strobe;
   logic [7:0] data_in;
   logic       load_ack;
   logic [3:0] load_addr;
   logic       load_done;
   logic       overflow;
   logic       cpu_hold;
   logic       cpu_rd_en;
   logic [3:0] cpu_rd_addr;
   logic [7:0] cpu_rd_data;

   int tests = 0;
   int fails = 0;

   sap1_program_loader #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .load_mode_i   (load_mode),
      .data_strobe_i (data_strobe),
      .data_in_i     (data_in),
      .load_ack_o    (load_ack),
      .load_addr_o   (load_addr),
      .load_done_o   (load_done),
      .overflow_o    (overflow),
      .cpu_hold_o    (cpu_hold),
      .cpu_rd_en_i   (cpu_rd_en),
      .cpu_rd_addr_i (cpu_rd_addr),
      .cpu_rd_data_o (cpu_rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic strobe_byte(input logic [7:0] d);
      int n;
      data_in     = d;
      data_strobe = 1'b1;
      n = 0;
      while (load_ack !== 1'b1 && n < 20) begin tick(1); n++; end
      check("ack_rise", 32'(load_ack), 32'd1);
      data_strobe = 1'b0;
      n = 0;
      while (load_ack !== 1'b0 && n < 20) begin tick(1); n++; end
      check("ack_fall", 32'(load_ack), 32'd0);
   endtask

   task automatic read_word(input logic [3:0] a, input logic [7:0] exp);
      cpu_rd_en   = 1'b1;
      cpu_rd_addr = a;
      tick(1);
      cpu_rd_en   = 1'b0;
      check($sformatf("rd[%0d]", a), 32'(cpu_rd_data), 32'(exp));
   endtask

   initial begin
      int n;
      rst_n = 1'b0; load_mode = 1'b0; data_strobe = 1'b0; data_in = '0;
      cpu_rd_en = 1'b0; cpu_rd_addr = '0;
      tick(3);
      check("rst_ack",   32'(load_ack),    32'd0);
      check("rst_addr",  32'(load_addr),   32'd0);
      check("rst_done",  32'(load_done),   32'd0);
      check("rst_ovf",   32'(overflow),    32'd0);
      check("rst_hold",  32'(cpu_hold),    32'd0);
      check("rst_rdata", 32'(cpu_rd_data), 32'd0);
      rst_n = 1'b1;
      tick(1);

      // 1: full 16-word load
      load_mode = 1'b1;
      tick(4);
      check("t1_hold", 32'(cpu_hold), 32'd1);
      for (int i = 0; i < 16; i++) strobe_byte(8'(8'h10 + i));
      check("t1_done",  32'(load_done),   32'd1);
      check("t1_addr",  32'(load_addr),   32'd0);
      check("t1_state", 32'(dut.state_q), 32'(ST_FULL));
      for (int i = 0; i < 16; i++) read_word(4'(i), 8'(8'h10 + i));

      // 2: strobe while FULL
      data_in = 8'h55; data_strobe = 1'b1;
      tick(6);
      check("t2_noack", 32'(load_ack), 32'd0);
      check("t2_ovf",   32'(overflow), 32'd1);
      data_strobe = 1'b0;
      tick(4);
      read_word(4'd0, 8'h10);

      // 3: partial session then mode drop
      load_mode = 1'b0;
      tick(6);
      check("t3_idle_hold", 32'(cpu_hold),  32'd0);
      check("t3_done_kept", 32'(load_done), 32'd1);
      check("t3_ovf_kept",  32'(overflow),  32'd1);
      load_mode = 1'b1;
      tick(4);
      check("t3_ovf_clr",  32'(overflow),  32'd0);
      check("t3_done_clr", 32'(load_done), 32'd0);
      strobe_byte(8'hAA); strobe_byte(8'hBB); strobe_byte(8'hCC);
      load_mode = 1'b0;
      n = 0;
      while (cpu_hold !== 1'b0 && n < 20) begin tick(1); n++; end
      check("t3_hold_lat", 32'(n), 32'd4);
      read_word(4'd0, 8'hAA); read_word(4'd1, 8'hBB);
      read_word(4'd2, 8'hCC); read_word(4'd3, 8'h13);

      // 4: strobe held high for 10 cycles
      load_mode = 1'b1;
      tick(4);
      data_in = 8'h44; data_strobe = 1'b1;
      tick(10);
      check("t4_ack_held", 32'(load_ack),  32'd1);
      check("t4_one_wr",   32'(load_addr), 32'd1);
      data_strobe = 1'b0;
      tick(4);
      check("t4_ack_low",  32'(load_ack),  32'd0);
      check("t4_addr",     32'(load_addr), 32'd1);
      read_word(4'd0, 8'h44); read_word(4'd1, 8'hBB);

      // 5: reset after two writes with a third in flight
      load_mode = 1'b0;
      tick(6);
      load_mode = 1'b1;
      tick(4);
      strobe_byte(8'h61); strobe_byte(8'h62);
      data_in = 8'h63; data_strobe = 1'b1;
      tick(2);
      rst_n = 1'b0;
      tick(1);
      check("t5_hold",  32'(cpu_hold),    32'd0);
      check("t5_ack",   32'(load_ack),    32'd0);
      check("t5_state", 32'(dut.state_q), 32'(ST_IDLE));
      rst_n = 1'b1; load_mode = 1'b0; data_strobe = 1'b0;
      tick(4);
      read_word(4'd0, 8'h61); read_word(4'd1, 8'h62); read_word(4'd2, 8'hCC);

      // 6: read/write collision at address 5
      load_mode = 1'b1;
      tick(4);
      for (int i = 0; i < 5; i++) strobe_byte(8'(8'h70 + i));
      data_in = 8'h75; data_strobe = 1'b1;
      tick(2);
      cpu_rd_en = 1'b1; cpu_rd_addr = 4'd5;
      tick(1);
      check("t6_wr_now", 32'(load_ack),    32'd1);
      check("t6_old",    32'(cpu_rd_data), 32'h15);
      tick(1);
      check("t6_new",    32'(cpu_rd_data), 32'h75);
      cpu_rd_en = 1'b0; data_strobe = 1'b0; load_mode = 1'b0;
      tick(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
